// File: rtl/seven_seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seven_seg_scan_ctrl
//
// Time-multiplexing scan controller for an 8-digit common-anode seven-segment
// display. A value is offered through a valid/ready handshake into a shadow
// register. It is copied into the display register only at a frame boundary,
// so a frame never shows a mix of old and new digits. Each digit slot lasts
// PRESCALE cycles. The first BLANK_CYC cycles of every slot keep all anodes
// off, which prevents ghosting.
//
// Optional feature macro: SEVEN_SEG_LZ_BLANK_EN
//   defined   -> leading-zero suppression. Slot k > 0 goes dark when display
//                nibbles k..7 are all zero. Digit 0 is always shown.
//   undefined -> every slot below N_DIG shows its nibble.
//
// Ports:
//   clk          in   system clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   i_value      in   [N-1:0] value to display; nibble k is shown on digit k
//   i_valid      in   i_value is offered for loading
//   o_ready      out  shadow register free; load occurs on i_valid & o_ready
//   i_digit_en   in   [7:0] per-slot enable; sampled at the start of ON
//   o_segments   out  [6:0] active-low segments {G,F,E,D,C,B,A}
//   o_anodos     out  [7:0] one-cold anode drive; bit k drives digit k
//   o_frame_done out  one-cycle pulse at the end of slot 7
// -----------------------------------------------------------------------------
module seven_seg_scan_ctrl #(
  parameter int N         = 32,
  parameter int PRESCALE  = 100000,
  parameter int BLANK_CYC = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [N-1:0] i_value,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [7:0]   i_digit_en,
  output logic [6:0]   o_segments,
  output logic [7:0]   o_anodos,
  output logic         o_frame_done
);

  localparam int             N_DIG      = (N + 3) / 4;
  localparam int             CW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0]  LAST_CNT   = CW'(PRESCALE - 1);
  localparam logic [CW-1:0]  BLANK_LAST = CW'(BLANK_CYC - 1);
  localparam logic [3:0]     N_DIG_L    = 4'(N_DIG);

  typedef enum logic [0:0] {
    ST_BLANK = 1'b0,
    ST_ON    = 1'b1
  } state_t;

  // Hex-to-seven-segment decode, active low, bit order GFE_DCBA
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h18;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      4'hF:    seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
    return seg;
  endfunction

  state_t        state_r, state_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic [2:0]    slot_r, slot_s;
  logic          en_r, en_s;
  logic [N-1:0]  shadow_r;
  logic [N-1:0]  display_r;
  logic          pending_r;

  logic          accept_s;
  logic          frame_end_s;
  logic [31:0]   display_32_s;
  logic [3:0]    nibble_s;
  logic          lz_dark_s;
  logic [7:0]    anodos_s;
  logic [6:0]    segments_s;

  assign accept_s     = i_valid & ~pending_r;
  assign o_ready      = ~pending_r;
  assign frame_end_s  = (state_r == ST_ON) && (cnt_r == LAST_CNT) && (slot_r == 3'd7);
  assign display_32_s = 32'(display_r);
  assign nibble_s     = display_32_s[{slot_r, 2'b00} +: 4];

`ifdef SEVEN_SEG_LZ_BLANK_EN
  // Mark slots whose nibble and every higher nibble are zero
  always_comb begin
    logic       zero_acc;
    logic [7:0] zero_from;
    zero_acc  = 1'b1;
    zero_from = 8'h00;
    for (int k = 7; k >= 0; k--) begin
      zero_acc     = zero_acc & (display_32_s[k*4 +: 4] == 4'h0);
      zero_from[k] = zero_acc;
    end
    lz_dark_s = (slot_r != 3'd0) && zero_from[slot_r];
  end
`else
  assign lz_dark_s = 1'b0;
`endif

  // Scan state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_BLANK;
      cnt_r   <= '0;
      slot_r  <= 3'd0;
      en_r    <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      slot_r  <= slot_s;
      en_r    <= en_s;
    end
  end

  // Scan next-state: the counter runs 0..PRESCALE-1 across BLANK and ON
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r + CW'(1);
    slot_s  = slot_r;
    en_s    = en_r;
    case (state_r)
      ST_BLANK: begin
        if (cnt_r == BLANK_LAST) begin
          state_s = ST_ON;
          en_s    = i_digit_en[slot_r];  // held for the whole ON phase
        end else begin
          state_s = ST_BLANK;
        end
      end
      ST_ON: begin
        if (cnt_r == LAST_CNT) begin
          state_s = ST_BLANK;
          cnt_s   = '0;
          slot_s  = slot_r + 3'd1;
        end else begin
          state_s = ST_ON;
        end
      end
      default: begin
        state_s = ST_BLANK;
        cnt_s   = '0;
        slot_s  = 3'd0;
        en_s    = 1'b0;
      end
    endcase
  end

  // Handshake and frame commit. A commit needs pending set and an accept
  // needs it clear, so the two cannot happen in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow_r  <= '0;
      pending_r <= 1'b0;
      display_r <= '0;
    end else if (frame_end_s && pending_r) begin
      display_r <= shadow_r;
      pending_r <= 1'b0;
    end else if (accept_s) begin
      shadow_r  <= i_value;
      pending_r <= 1'b1;
    end
  end

  // Pin drive decode; it is registered below, one stage behind the scan state
  always_comb begin
    anodos_s   = 8'hFF;
    segments_s = 7'h7F;
    if ((state_r == ST_ON) && en_r && ({1'b0, slot_r} < N_DIG_L) && !lz_dark_s) begin
      anodos_s   = ~(8'h01 << slot_r);
      segments_s = hex_to_seg(nibble_s);
    end else begin
      anodos_s   = 8'hFF;
      segments_s = 7'h7F;
    end
  end

  // Output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      o_anodos     <= 8'hFF;
      o_segments   <= 7'h7F;
      o_frame_done <= 1'b0;
    end else begin
      o_anodos     <= anodos_s;
      o_segments   <= segments_s;
      o_frame_done <= frame_end_s;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// Self-checking bench for seven_seg_scan_ctrl with N=16, PRESCALE=8, BLANK_CYC=2.
// A reference model counts cycles since reset release and computes the
// slot/phase with plain arithmetic. The frame commit and handshake are modelled
// as simple variables.
// -----------------------------------------------------------------------------
module tb_seven_seg_scan_ctrl;

  localparam int N    = 16;
  localparam int P    = 8;
  localparam int B    = 2;
  localparam int FR   = 8 * P;
  localparam int NDIG = (N + 3) / 4;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [N-1:0] i_value = '0;
  logic         i_valid = 1'b0;
  logic [7:0]   i_digit_en = 8'hFF;
  logic         o_ready;
  logic [6:0]   o_segments;
  logic [7:0]   o_anodos;
  logic         o_frame_done;

  seven_seg_scan_ctrl #(.N(N), .PRESCALE(P), .BLANK_CYC(B)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_value      (i_value),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .i_digit_en   (i_digit_en),
    .o_segments   (o_segments),
    .o_anodos     (o_anodos),
    .o_frame_done (o_frame_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  int           t;        // rising edges since reset release
  logic [N-1:0] disp_m;
  logic [N-1:0] shadow_m;
  bit           pend_m;
  bit           en_m;

  logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at t=%0d: got %0h expected %0h", tag, t, got, exp);
    end
  endtask

  task automatic model_reset();
    t        = 0;
    disp_m   = '0;
    shadow_m = '0;
    pend_m   = 1'b0;
    en_m     = 1'b0;
  endtask

  // Advance one clock, predict the registered outputs and compare them
  task automatic step();
    int          q, slot, off;
    bit          lit;
    logic [31:0] d32;
    logic [7:0]  ea;
    logic [6:0]  es;
    logic        efd;
    q    = t;
    slot = (q / P) % 8;
    off  = q % P;
    d32  = 32'(disp_m);
    lit  = (off >= B) && en_m && (slot < NDIG);
`ifdef SEVEN_SEG_LZ_BLANK_EN
    if (slot > 0 && ((d32 >> (4 * slot)) == 32'd0)) lit = 1'b0;
`endif
    ea  = lit ? ~(8'h01 << slot) : 8'hFF;
    es  = lit ? hex_tab[(d32 >> (4 * slot)) & 32'hF] : 7'h7F;
    efd = (q % FR) == (FR - 1);
    if (off == B - 1) en_m = i_digit_en[slot];
    if (((q % FR) == (FR - 1)) && pend_m) begin
      disp_m = shadow_m;
      pend_m = 1'b0;
    end else if (i_valid && !pend_m) begin
      shadow_m = i_value;
      pend_m   = 1'b1;
    end
    @(posedge clk);
    #1;
    t++;
    check_val("anodos", 32'(o_anodos), 32'(ea));
    check_val("segments", 32'(o_segments), 32'(es));
    check_val("frame_done", 32'(o_frame_done), 32'(efd));
    check_val("ready", 32'(o_ready), 32'(!pend_m));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic drive_load(input logic [N-1:0] v);
    i_value = v;
    i_valid = 1'b1;
    step();
    i_valid = 1'b0;
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_anodos", 32'(o_anodos), 32'h0FF);
    check_val("rst_segments", 32'(o_segments), 32'h07F);
    check_val("rst_ready", 32'(o_ready), 32'h1);
    check_val("rst_frame_done", 32'(o_frame_done), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    run(3);
    check_val("first_on_anodos", 32'(o_anodos), 32'h0FE);
    check_val("first_on_segments", 32'(o_segments), 32'h040);
    run(7);                       // t = 10
    drive_load(16'h12AF);         // accepted at edge 11
    check_val("ready_low_after_load", 32'(o_ready), 32'h0);
    run(9);
    drive_load(16'hDEAD);         // offered while pending, must be ignored
    run(64 - t);
    check_val("first_frame_done", 32'(o_frame_done), 32'h1);
    run(FR);

    i_digit_en = 8'hFB;
    drive_load(16'h1234);
    run(2 * FR);
    i_digit_en = 8'hFF;
    drive_load(16'h0005);
    run(2 * FR);

    for (int i = 0; i < 1500; i++) begin
      i_valid = ($urandom % 16) == 0;
      i_value = N'($urandom);
      if (($urandom % 32) == 0) i_digit_en = 8'($urandom);
      step();
    end
    i_valid    = 1'b0;
    i_digit_en = 8'hFF;

    // Get a load pending, then reset in the middle of slot 5
    for (int i = 0; i < 2 * FR && ((t / P) % 8) != 1; i++) step();
    if (!pend_m) drive_load(16'h4321);
    for (int i = 0; i < 2 * FR && !(((t / P) % 8) == 5 && (t % P) == 3); i++) step();
    check_val("pending_before_reset", 32'(o_ready), 32'(!pend_m));
    #3;
    reset_n = 1'b0;
    #1;
    check_val("midrst_anodos", 32'(o_anodos), 32'h0FF);
    check_val("midrst_segments", 32'(o_segments), 32'h07F);
    check_val("midrst_ready", 32'(o_ready), 32'h1);
    check_val("midrst_frame_done", 32'(o_frame_done), 32'h0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    run(2 * FR);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
